// File: rtl/lb_config_sequencer.sv
// Plays a table of {last, addr, data} local-bus writes onto the shared lb_* bus,
// with host writes passing through and always taking precedence over table writes.
module lb_config_sequencer #(
  parameter int aw    = 15,
  parameter int dw    = 32,
  parameter int ta    = 8,
  parameter int gap_w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [gap_w-1:0] gap,
  output logic [ta-1:0]    rom_addr,
  input  logic [aw+dw:0]   rom_data,
  input  logic [aw-1:0]    host_addr,
  input  logic [dw-1:0]    host_data,
  input  logic             host_write,
  output logic [aw-1:0]    lb_addr,
  output logic [dw-1:0]    lb_data,
  output logic             lb_write,
  output logic             busy,
  output logic             done,
  output logic [ta:0]      count,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [ta-1:0] addr_max  = '1;
  localparam logic [ta:0]   count_max = {1'b1, {ta{1'b0}}};

  state_t           state;
  logic [gap_w-1:0] gap_q;
  logic [gap_w-1:0] gap_cnt;

  logic             rom_last;
  logic [aw-1:0]    rom_a;
  logic [dw-1:0]    rom_d;
  logic             grant;
  logic             final_entry;

  assign {rom_last, rom_a, rom_d} = rom_data;

  // A table write goes out only when the host is silent and no abort is pending.
  assign grant       = (state == S_WRITE) && !host_write && !abort;
  assign final_entry = rom_last || (rom_addr == addr_max);

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // only seen at a rising edge; every register gets a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gap_q    <= '0;
      gap_cnt  <= '0;
      rom_addr <= '0;
      lb_addr  <= '0;
      lb_data  <= '0;
      lb_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge values and a later assignment in the block simply wins.
      done <= 1'b0;

      if (host_write) begin
        lb_addr  <= host_addr;
        lb_data  <= host_data;
        lb_write <= 1'b1;
      end else if (grant) begin
        lb_addr  <= rom_a;
        lb_data  <= rom_d;
        lb_write <= 1'b1;
      end else begin
        lb_write <= 1'b0;
      end

      if (grant && (count != count_max)) count <= count + 1'b1;

      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              state    <= S_FETCH;
              busy     <= 1'b1;
              rom_addr <= '0;
              count    <= '0;
              overrun  <= 1'b0;
              gap_q    <= gap;
            end
          end
          S_FETCH: state <= S_WRITE;
          S_WRITE: begin
            if (!host_write) begin
              if (final_entry) begin
                state <= S_DONE;
                if (!rom_last) overrun <= 1'b1;
              end else begin
                rom_addr <= rom_addr + 1'b1;
                if (gap_q != '0) begin
                  state   <= S_GAP;
                  gap_cnt <= gap_q;
                end else begin
                  state <= S_FETCH;
                end
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == gap_w'(1)) state <= S_FETCH;
            else                      gap_cnt <= gap_cnt - 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lb_config_sequencer.sv
// Bench for lb_config_sequencer: cycle vectors, directed corner sequences and
// randomized tables checked against a transaction-level expectation.
module tb_lb_config_sequencer;

  localparam int aw = 15;
  localparam int dw = 32;
  localparam int ta = 3;
  localparam int gw = 8;
  localparam int n_rom = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [gw-1:0] gap = '0;
  logic [ta-1:0] rom_addr;
  logic [aw+dw:0] rom_data;
  logic [aw-1:0] host_addr = '0;
  logic [dw-1:0] host_data = '0;
  logic          host_write = 1'b0;
  logic [aw-1:0] lb_addr;
  logic [dw-1:0] lb_data;
  logic          lb_write;
  logic          busy;
  logic          done;
  logic [ta:0]   count;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  lb_config_sequencer #(.aw(aw), .dw(dw), .ta(ta), .gap_w(gw)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .gap(gap),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .host_addr(host_addr), .host_data(host_data), .host_write(host_write),
    .lb_addr(lb_addr), .lb_data(lb_data), .lb_write(lb_write),
    .busy(busy), .done(done), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Table contents and a synchronous-read ROM in front of the DUT.
  logic [aw-1:0]  tbl_addr [n_rom];
  logic [dw-1:0]  tbl_data [n_rom];
  logic           tbl_last [n_rom];
  logic [aw+dw:0] rom_mem  [n_rom];

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic load_rom();
    for (int k = 0; k < n_rom; k++) rom_mem[k] = {tbl_last[k], tbl_addr[k], tbl_data[k]};
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_t1(input bit with_last);
    for (int k = 0; k < n_rom; k++) begin
      tbl_addr[k] = (k < 3) ? aw'(15'h0101 * (k + 1)) : aw'(15'h7f00 + k);
      tbl_data[k] = (k < 3) ? 32'hc0de_0000 + 32'(k * 32'h1111) : 32'hdead_0000 + 32'(k);
      tbl_last[k] = with_last && (k == 2);
    end
    load_rom();
  endtask

  typedef struct {
    bit            go;
    bit            hw;
    logic [aw-1:0] haddr;
    logic [dw-1:0] hdata;
    bit            exp_write;
    logic [aw-1:0] exp_addr;
    logic [dw-1:0] exp_data;
    bit            exp_done;
    bit            chk_busy;
    bit            exp_busy;
    bit            chk_count;
    logic [ta:0]   exp_count;
  } vec_t;

  vec_t vecs [24];

  // Per-cycle capture for directed sequences; go is driven in cycle 0.
  int            beat_cyc [$];
  logic [aw-1:0] beat_addr [$];
  logic [dw-1:0] beat_data [$];
  int            done_cyc [$];
  logic          busy_log [64];
  logic          wr_log   [64];
  logic [ta-1:0] ra_log   [64];

  task automatic run_seq(input int ncyc, input int abort_at, input int rst_at);
    beat_cyc.delete(); beat_addr.delete(); beat_data.delete(); done_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (lb_write) begin
        beat_cyc.push_back(c);
        beat_addr.push_back(lb_addr);
        beat_data.push_back(lb_data);
      end
      if (done) done_cyc.push_back(c);
      busy_log[c] = busy;
      wr_log[c]   = lb_write;
      ra_log[c]   = rom_addr;
      go    = (c == 0);
      abort = (c == abort_at);
      rst_n = (c != rst_at);
      tick();
    end
    go = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset lb_write", lb_write, 0);
    check("reset lb_addr", lb_addr, 0);
    check("reset lb_data", lb_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset count", count, 0);
    check("reset overrun", overrun, 0);
    check("reset rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven cycle vectors: basic 3-entry run (with go during DONE), then host stall.
    load_t1(1'b1);
    gap = '0;
    for (int i = 0; i < 24; i++) vecs[i] = '{default: 0};
    vecs[0].go = 1;
    vecs[1].chk_busy = 1; vecs[1].exp_busy = 1;
    for (int e = 0; e < 3; e++) begin
      vecs[3 + 2 * e].exp_write = 1;
      vecs[3 + 2 * e].exp_addr  = tbl_addr[e];
      vecs[3 + 2 * e].exp_data  = tbl_data[e];
      vecs[16 + 2 * e].exp_write = 1;
      vecs[16 + 2 * e].exp_addr  = tbl_addr[e];
      vecs[16 + 2 * e].exp_data  = tbl_data[e];
    end
    vecs[7].go = 1;
    vecs[8].exp_done = 1;
    vecs[9].chk_busy = 1; vecs[9].chk_count = 1; vecs[9].exp_count = 3;
    vecs[10].go = 1;
    for (int k = 0; k < 3; k++) begin
      vecs[12 + k].hw    = 1;
      vecs[12 + k].haddr = aw'(15'h6000 + k);
      vecs[12 + k].hdata = 32'h5a5a_0000 + 32'(k);
      vecs[13 + k].exp_write = 1;
      vecs[13 + k].exp_addr  = aw'(15'h6000 + k);
      vecs[13 + k].exp_data  = 32'h5a5a_0000 + 32'(k);
    end
    vecs[21].exp_done = 1;
    vecs[22].chk_busy = 1; vecs[22].chk_count = 1; vecs[22].exp_count = 3;

    for (int i = 0; i < 24; i++) begin
      check($sformatf("vec%0d lb_write", i), lb_write, vecs[i].exp_write);
      if (vecs[i].exp_write) begin
        check($sformatf("vec%0d lb_addr", i), lb_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d lb_data", i), lb_data, vecs[i].exp_data);
      end
      check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
      if (vecs[i].chk_busy)  check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].chk_count) check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
      go         = vecs[i].go;
      host_write = vecs[i].hw;
      host_addr  = vecs[i].haddr;
      host_data  = vecs[i].hdata;
      tick();
    end

    // Gap of 4 stretches the period to 6 cycles.
    gap = 8'd4;
    run_seq(20, -1, -1);
    check("gap beats", beat_cyc.size(), 3);
    check("gap beat0 cyc", beat_cyc[0], 3);
    check("gap beat1 cyc", beat_cyc[1], 9);
    check("gap beat2 cyc", beat_cyc[2], 15);
    check("gap beat1 addr", beat_addr[1], tbl_addr[1]);
    check("gap done cyc", done_cyc[0], 16);

    // Table without a last flag runs to the end of the address space.
    load_t1(1'b0);
    gap = '0;
    run_seq(22, -1, -1);
    check("ovr beats", beat_cyc.size(), 8);
    check("ovr last beat cyc", beat_cyc[7], 17);
    check("ovr last beat data", beat_data[7], tbl_data[7]);
    check("ovr done cyc", done_cyc[0], 18);
    check("ovr overrun", overrun, 1);
    check("ovr count", count, 8);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("ovr cleared by go", overrun, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in fetch busy", busy, 0);
    tick();

    // Abort in the WRITE cycle of entry 1.
    load_t1(1'b1);
    run_seq(12, 4, -1);
    check("abort beats", beat_cyc.size(), 1);
    check("abort no write", wr_log[5], 0);
    check("abort busy", busy_log[5], 0);
    check("abort no done", done_cyc.size(), 0);
    check("abort count", count, 1);

    // Reset in the middle of a gap, then replay.
    gap = 8'd4;
    run_seq(10, -1, 4);
    check("rst gap rom_addr before", ra_log[4], 1);
    check("rst lb_write", wr_log[5], 0);
    check("rst busy", busy_log[5], 0);
    check("rst rom_addr", ra_log[5], 0);
    check("rst beats", beat_cyc.size(), 1);
    gap = '0;
    run_seq(12, -1, -1);
    check("replay beat0 cyc", beat_cyc[0], 3);
    check("replay beat0 addr", beat_addr[0], tbl_addr[0]);
    check("replay beats", beat_cyc.size(), 3);

    // Randomized tables, gaps, host traffic and aborts.
    for (int it = 0; it < 40; it++) begin
      int lastpos, n_exp, g, ab_cyc, got, dones, done_c, last_beat, cyc;
      bit host_mode, abort_mode, aborted, prev_hw;
      logic [aw-1:0] pha;
      logic [dw-1:0] phd;
      lastpos = $urandom_range(8, 0);
      for (int k = 0; k < n_rom; k++) begin
        tbl_addr[k] = aw'($urandom);
        tbl_data[k] = $urandom;
        tbl_last[k] = (k == lastpos);
      end
      load_rom();
      n_exp = (lastpos == 8) ? 8 : lastpos + 1;
      g = $urandom_range(3, 0);
      gap = gw'(g);
      host_mode = it[0];
      abort_mode = (it % 4 == 3);
      ab_cyc = $urandom_range(30, 1);
      aborted = 0; prev_hw = 0; got = 0; dones = 0; done_c = -1; last_beat = -1;
      pha = '0; phd = '0;
      for (cyc = 0; cyc < 300; cyc++) begin
        if (prev_hw) begin
          check("rnd host write", lb_write, 1);
          check("rnd host addr", lb_addr, pha);
          check("rnd host data", lb_data, phd);
        end else if (lb_write) begin
          if (got < n_exp) begin
            check("rnd tbl addr", lb_addr, tbl_addr[got]);
            check("rnd tbl data", lb_data, tbl_data[got]);
            if (!host_mode) check("rnd beat cycle", cyc, 3 + got * (2 + g));
          end else begin
            check("rnd extra beat", lb_write, 0);
          end
          got++;
          last_beat = cyc;
        end
        if (done) begin
          dones++;
          done_c = cyc;
        end
        if (cyc >= 2 && !busy) break;
        go = (cyc == 0);
        host_write = host_mode && ($urandom_range(3, 0) == 0);
        host_addr = aw'($urandom);
        host_data = $urandom;
        abort = abort_mode && (cyc == ab_cyc);
        if (abort && busy) aborted = 1;
        prev_hw = host_write;
        pha = host_addr;
        phd = host_data;
        tick();
      end
      if (cyc == 300) check("rnd timeout busy", busy, 0);
      host_write = 1'b0;
      abort = 1'b0;
      go = 1'b0;
      tick();
      check("rnd count", count, got);
      if (aborted) begin
        check("rnd abort no done", dones, 0);
      end else begin
        check("rnd beats", got, n_exp);
        check("rnd done pulses", dones, 1);
        check("rnd overrun", overrun, lastpos == 8);
        if (!host_mode) check("rnd done cycle", done_c, last_beat + 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
